arf_rat: RTL and testbench

- Architectural register file plus register alias table (RAT). Sits on the consumer side of the ROB retire/redirect interface, and on the producer side of the ROB register-read request (rob_id_src1/2).
- At dispatch it renames each source to either committed ARF data or the producing ROB id. It records the new producer of each destination.
- At retire it commits data into the ARF and releases the mapping. A redirect flushes every speculative mapping.

---
 rtl/arf_rat.sv | 109 ++++++++++
 tb/tb_arf_rat.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/arf_rat.sv
// Architectural register file and register alias table: renames dispatch sources, commits retires, flushes on redirect.
// Optional same-cycle retire-to-read forwarding is enabled by defining ARF_RETIRE_BYPASS_EN.
module arf_rat #(
  parameter int unsigned N_ARF          = 32,
  parameter int unsigned ARF_ID_WIDTH   = 5,
  parameter int unsigned ROB_ID_WIDTH   = 4,
  parameter int unsigned REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dispatch_fire,
  input  logic [ARF_ID_WIDTH-1:0]   dispatch_src1_arf_id,
  input  logic [ARF_ID_WIDTH-1:0]   dispatch_src2_arf_id,
  input  logic                      dispatch_dst_valid,
  input  logic [ARF_ID_WIDTH-1:0]   dispatch_dst_arf_id,
  input  logic [ROB_ID_WIDTH-1:0]   dispatch_rob_id,
  output logic                      src1_renamed,
  output logic [ROB_ID_WIDTH-1:0]   src1_rob_id,
  output logic [REG_DATA_WIDTH-1:0] src1_arf_data,
  output logic                      src2_renamed,
  output logic [ROB_ID_WIDTH-1:0]   src2_rob_id,
  output logic [REG_DATA_WIDTH-1:0] src2_arf_data,
  input  logic                      retire,
  input  logic [ROB_ID_WIDTH-1:0]   retire_rob_id,
  input  logic [ARF_ID_WIDTH-1:0]   retire_arf_id,
  input  logic [REG_DATA_WIDTH-1:0] retire_reg_data,
  input  logic                      retire_redirect_pc_valid,
  output logic [ARF_ID_WIDTH:0]     n_renamed
);

  logic [REG_DATA_WIDTH-1:0] arf_q        [N_ARF];
  logic [REG_DATA_WIDTH-1:0] arf_d        [N_ARF];
  logic [ROB_ID_WIDTH-1:0]   rat_rob_id_q [N_ARF];
  logic [ROB_ID_WIDTH-1:0]   rat_rob_id_d [N_ARF];
  logic [N_ARF-1:0]          rat_valid_q;
  logic [N_ARF-1:0]          rat_valid_d;
  logic [ARF_ID_WIDTH:0]     n_renamed_q;
  logic [ARF_ID_WIDTH:0]     n_renamed_d;

  logic rename_en;
  logic retire_wr;
  logic retire_clr;
  logic rename_new;

  always_comb begin
    rename_en  = dispatch_fire & dispatch_dst_valid & (dispatch_dst_arf_id != '0)
               & ~retire_redirect_pc_valid;
    retire_wr  = retire & (retire_arf_id != '0);
    // A same-cycle rename of the retiring register keeps the entry live (younger producer).
    retire_clr = retire_wr & ~retire_redirect_pc_valid & rat_valid_q[retire_arf_id]
               & (rat_rob_id_q[retire_arf_id] == retire_rob_id)
               & ~(rename_en & (dispatch_dst_arf_id == retire_arf_id));
    rename_new = rename_en & ~rat_valid_q[dispatch_dst_arf_id];

    arf_d        = arf_q;
    rat_valid_d  = rat_valid_q;
    rat_rob_id_d = rat_rob_id_q;
    if (retire_wr) arf_d[retire_arf_id] = retire_reg_data;

    if (retire_redirect_pc_valid) begin
      rat_valid_d = '0;
      n_renamed_d = '0;
    end else begin
      if (retire_clr) rat_valid_d[retire_arf_id] = 1'b0;
      if (rename_en) begin
        rat_valid_d[dispatch_dst_arf_id]  = 1'b1;
        rat_rob_id_d[dispatch_dst_arf_id] = dispatch_rob_id;
      end
      n_renamed_d = n_renamed_q + (ARF_ID_WIDTH+1)'(rename_new)
                  - (ARF_ID_WIDTH+1)'(retire_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arf_q        <= '{default: '0};
      rat_rob_id_q <= '{default: '0};
      rat_valid_q  <= '0;
      n_renamed_q  <= '0;
    end else begin
      arf_q        <= arf_d;
      rat_rob_id_q <= rat_rob_id_d;
      rat_valid_q  <= rat_valid_d;
      n_renamed_q  <= n_renamed_d;
    end
  end

  always_comb begin
    src1_renamed  = (dispatch_src1_arf_id != '0) & rat_valid_q[dispatch_src1_arf_id];
    src1_rob_id   = rat_rob_id_q[dispatch_src1_arf_id];
    src1_arf_data = (dispatch_src1_arf_id == '0) ? '0 : arf_q[dispatch_src1_arf_id];
    src2_renamed  = (dispatch_src2_arf_id != '0) & rat_valid_q[dispatch_src2_arf_id];
    src2_rob_id   = rat_rob_id_q[dispatch_src2_arf_id];
    src2_arf_data = (dispatch_src2_arf_id == '0) ? '0 : arf_q[dispatch_src2_arf_id];
`ifdef ARF_RETIRE_BYPASS_EN
    if (retire_wr && (retire_arf_id == dispatch_src1_arf_id)) begin
      src1_arf_data = retire_reg_data;
      if (rat_rob_id_q[dispatch_src1_arf_id] == retire_rob_id) src1_renamed = 1'b0;
    end
    if (retire_wr && (retire_arf_id == dispatch_src2_arf_id)) begin
      src2_arf_data = retire_reg_data;
      if (rat_rob_id_q[dispatch_src2_arf_id] == retire_rob_id) src2_renamed = 1'b0;
    end
`endif
  end

  assign n_renamed = n_renamed_q;

endmodule

// File: tb/tb_arf_rat.sv
// Scoreboard bench for arf_rat: directed scenarios then random traffic against an array-based register model.
module tb_arf_rat;

  logic        clk;
  logic        rst;
  logic        dispatch_fire;
  logic [4:0]  dispatch_src1_arf_id;
  logic [4:0]  dispatch_src2_arf_id;
  logic        dispatch_dst_valid;
  logic [4:0]  dispatch_dst_arf_id;
  logic [3:0]  dispatch_rob_id;
  logic        src1_renamed;
  logic [3:0]  src1_rob_id;
  logic [31:0] src1_arf_data;
  logic        src2_renamed;
  logic [3:0]  src2_rob_id;
  logic [31:0] src2_arf_data;
  logic        retire;
  logic [3:0]  retire_rob_id;
  logic [4:0]  retire_arf_id;
  logic [31:0] retire_reg_data;
  logic        retire_redirect_pc_valid;
  logic [5:0]  n_renamed;

  arf_rat #(.N_ARF(32), .ARF_ID_WIDTH(5), .ROB_ID_WIDTH(4), .REG_DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .dispatch_fire(dispatch_fire),
    .dispatch_src1_arf_id(dispatch_src1_arf_id),
    .dispatch_src2_arf_id(dispatch_src2_arf_id),
    .dispatch_dst_valid(dispatch_dst_valid),
    .dispatch_dst_arf_id(dispatch_dst_arf_id),
    .dispatch_rob_id(dispatch_rob_id),
    .src1_renamed(src1_renamed), .src1_rob_id(src1_rob_id), .src1_arf_data(src1_arf_data),
    .src2_renamed(src2_renamed), .src2_rob_id(src2_rob_id), .src2_arf_data(src2_arf_data),
    .retire(retire), .retire_rob_id(retire_rob_id), .retire_arf_id(retire_arf_id),
    .retire_reg_data(retire_reg_data),
    .retire_redirect_pc_valid(retire_redirect_pc_valid),
    .n_renamed(n_renamed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          r1;
    logic [3:0]  id1;
    logic [31:0] d1;
    bit          r2;
    logic [3:0]  id2;
    logic [31:0] d2;
    int          n;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: committed values, and which ROB id (if any) each register waits on.
  logic [31:0] m_arf [32];
  bit          m_pend[32];
  logic [3:0]  m_rob [32];
  bit          known = 0;

  function automatic int pending_count();
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  function automatic void exp_read(input int s, input bit rt, input int rrob, input int rid,
                                   input logic [31:0] rdata, output bit ren,
                                   output logic [3:0] rob, output logic [31:0] dat);
    ren = (s != 0) && m_pend[s];
    rob = m_rob[s];
    dat = (s == 0) ? 32'h0 : m_arf[s];
`ifdef ARF_RETIRE_BYPASS_EN
    if (rt && rid != 0 && rid == s) begin
      dat = rdata;
      if (m_rob[s] == 4'(rrob)) ren = 0;
    end
`else
    if (rt && rid == s && rrob < 0 && rdata == 0) ren = ren;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, expv, $time);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit dv, input int d, input int drob,
                      input int s1, input int s2, input bit rt, input int rrob, input int rid,
                      input logic [31:0] rdata, input bit redir);
    exp_t e;
    @(negedge clk);
    rst = r; dispatch_fire = f; dispatch_dst_valid = dv;
    dispatch_dst_arf_id = 5'(d); dispatch_rob_id = 4'(drob);
    dispatch_src1_arf_id = 5'(s1); dispatch_src2_arf_id = 5'(s2);
    retire = rt; retire_rob_id = 4'(rrob); retire_arf_id = 5'(rid);
    retire_reg_data = rdata; retire_redirect_pc_valid = redir;
    if (known) begin
      exp_read(s1, rt, rrob, rid, rdata, e.r1, e.id1, e.d1);
      exp_read(s2, rt, rrob, rid, rdata, e.r2, e.id2, e.d2);
      e.n = pending_count();
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_arf[i] = 0; m_pend[i] = 0; m_rob[i] = 0; end
      known = 1;
    end else begin
      if (rt && rid != 0) m_arf[rid] = rdata;
      if (redir) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
      end else begin
        if (rt && rid != 0 && m_rob[rid] == 4'(rrob)) m_pend[rid] = 0;
        if (f && dv && d != 0) begin m_pend[d] = 1; m_rob[d] = 4'(drob); end
      end
    end
  endtask

  task automatic idle(input int s1, input int s2);
    step(0, 0, 0, 0, 0, s1, s2, 0, 0, 0, 32'h0, 0);
  endtask

  function automatic int rand_id();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  // Monitor: outputs are combinational, sampled mid-cycle after the driver settles inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("src1_renamed", 32'(src1_renamed), 32'(e.r1));
        chk("src1_rob_id", 32'(src1_rob_id), 32'(e.id1));
        chk("src1_arf_data", src1_arf_data, e.d1);
        chk("src2_renamed", 32'(src2_renamed), 32'(e.r2));
        chk("src2_rob_id", 32'(src2_rob_id), 32'(e.id2));
        chk("src2_arf_data", src2_arf_data, e.d2);
        chk("n_renamed", 32'(n_renamed), 32'(e.n));
      end
    end
  end

  initial begin
    rst = 1; dispatch_fire = 0; dispatch_dst_valid = 0; dispatch_dst_arf_id = 0;
    dispatch_rob_id = 0; dispatch_src1_arf_id = 0; dispatch_src2_arf_id = 0;
    retire = 0; retire_rob_id = 0; retire_arf_id = 0; retire_reg_data = 0;
    retire_redirect_pc_valid = 0;

    step(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 32'h0, 0);
    idle(3, 0);
    step(0, 1, 1, 5, 7, 5, 5, 0, 0, 0, 32'h0, 0);
    idle(5, 0);
    step(0, 0, 0, 0, 0, 5, 0, 1, 7, 5, 32'hDEADBEEF, 0);
    idle(5, 0);
    step(0, 1, 1, 5, 2, 5, 0, 0, 0, 0, 32'h0, 0);
    step(0, 1, 1, 5, 9, 5, 0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 5, 0, 1, 2, 5, 32'h11, 0);
    idle(5, 0);
    step(0, 1, 1, 1, 3, 1, 2, 0, 0, 0, 32'h0, 0);
    step(0, 1, 1, 2, 4, 1, 2, 0, 0, 0, 32'h0, 0);
    step(0, 1, 1, 6, 5, 1, 2, 0, 0, 0, 32'h0, 1);
    idle(1, 2);
    idle(6, 0);
    step(0, 1, 1, 4, 1, 4, 0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 4, 4, 1, 1, 4, 32'h55, 0);
    idle(4, 0);
    step(0, 1, 1, 0, 6, 0, 0, 0, 0, 0, 32'h0, 0);
    idle(0, 0);
    // Rename and retire the same register in one cycle: new mapping must survive.
    step(0, 1, 1, 7, 12, 7, 0, 0, 0, 0, 32'h0, 0);
    step(0, 1, 1, 7, 13, 7, 0, 1, 12, 7, 32'hA5A5, 0);
    idle(7, 0);
    // Retire to x0 is dropped.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF, 0);
    idle(0, 0);
    // Fill every register to reach the counter ceiling, then re-rename without growth.
    for (int i = 1; i < 32; i++) step(0, 1, 1, i, i % 16, i, 0, 0, 0, 0, 32'h0, 0);
    idle(31, 1);
    step(0, 1, 1, 9, 3, 9, 0, 0, 0, 0, 32'h0, 0);
    idle(9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    idle(9, 31);

    for (int k = 0; k < 3000; k++) begin
      int rid;
      int rrob;
      rid  = rand_id();
      rrob = ($urandom_range(0, 1) == 1) ? int'(m_rob[rid]) : int'($urandom_range(0, 15));
      step(bit'($urandom_range(0, 199) == 0),
           bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 4) != 0),
           rand_id(), int'($urandom_range(0, 15)), rand_id(), rand_id(),
           bit'($urandom_range(0, 2) == 0), rrob, rid, $urandom(),
           bit'($urandom_range(0, 24) == 0));
    end

    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
